// File: rtl/jk_count_sequencer.sv
// Mod-MOD up/down counter with parallel load, expressed as JK excitation for an external flop bank.
// One-cycle latency to bank output; ld_ready stays low whenever the bank readback disagrees with q.
module jk_count_sequencer #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [WIDTH-1:0] fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             mismatch
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic [1:0] {CLR, RUN, ERR} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] qn;
  logic             in_sync;
  logic             tc_raw;

  assign in_sync = (fb == q);
  assign tc_raw  = en && !ld_valid &&
                   ((up_dn && (q == MAX_VAL)) || (!up_dn && (q == '0)));

  // Load beats count beats hold; oversized loads saturate to the top legal value.
  always_comb begin
    qn = q;
    if (ld_valid) begin
      qn = ({1'b0, ld_data} >= MOD_EXT) ? MAX_VAL : ld_data;
    end else if (en && up_dn) begin
      qn = (q == MAX_VAL) ? '0 : q + ONE;
    end else if (en) begin
      qn = (q == '0) ? MAX_VAL : q - ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= CLR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLR:     state_nxt = RUN;
      RUN:     if (!in_sync) state_nxt = ERR;
      ERR:     if (in_sync)  state_nxt = RUN;
      default: state_nxt = CLR;
    endcase
  end

  always_comb begin
    j        = '0;
    k        = '0;
    ld_ready = 1'b0;
    tc       = 1'b0;
    if (!reset || state == CLR) begin
      k = '1;
    end else if (state == RUN && in_sync) begin
      j        = ~q & qn;
      k        = q & ~qn;
      ld_ready = 1'b1;
      tc       = tc_raw;
    end else begin
      // Drive the bank back toward q rather than advancing the count.
      j  = ~fb & q;
      k  = fb & ~q;
      tc = (state == RUN) && tc_raw;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      q        <= '0;
      mismatch <= 1'b0;
    end else if (state == RUN) begin
      if (in_sync) begin
        q <= qn;
      end else begin
        mismatch <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Scoreboard bench: stimulus queues expected values per cycle, a negedge monitor pops and compares.
// A behavioural JK bank closes the fb loop; fb can be overridden to inject divergence.
module tb_jk_count_sequencer;

  logic       clock = 1'b0;
  logic       reset, en, up_dn, ld_valid, ld_ready;
  logic [3:0] ld_data, fb, j, k, q;
  logic       tc, mismatch;

  logic [3:0] y = 4'h0;
  logic       force_en;
  logic [3:0] force_val;

  jk_count_sequencer #(.WIDTH(4), .MOD(10)) dut (
    .clock(clock), .reset(reset), .en(en), .up_dn(up_dn),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .fb(fb), .j(j), .k(k), .q(q), .tc(tc), .mismatch(mismatch)
  );

  always #5 clock = ~clock;

  // JK flop bank: y+ = j&~y | ~k&y
  always @(posedge clock) y <= (j & ~y) | (~k & y);
  assign fb = force_en ? force_val : y;

  typedef enum int {S_Q, S_J, S_K, S_TC, S_RDY, S_MM} sig_e;
  typedef struct {
    int         cyc;
    string      nm;
    sig_e       sig;
    logic [3:0] val;
  } item_t;

  item_t      sb[$];
  item_t      it;
  logic [3:0] act;
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [3:0] pick(sig_e s);
    case (s)
      S_Q:     return q;
      S_J:     return j;
      S_K:     return k;
      S_TC:    return {3'b000, tc};
      S_RDY:   return {3'b000, ld_ready};
      default: return {3'b000, mismatch};
    endcase
  endfunction

  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it  = sb.pop_front();
      act = pick(it.sig);
      checks++;
      if (it.cyc != cyc || act !== it.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)", it.nm, act, it.val, cyc, it.cyc);
      end
    end
  end

  task automatic ex(input string nm, input sig_e s, input logic [3:0] v);
    sb.push_back('{cyc, nm, s, v});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e;
    reset = 1'b0; en = 1'b1; up_dn = 1'b0; ld_valid = 1'b1; ld_data = 4'd3;
    force_en = 1'b0; force_val = 4'h0;

    // Reset held low: clear excitation even with load and count requested
    tick();
    ex("rst_q", S_Q, 0); ex("rst_j", S_J, 0); ex("rst_k", S_K, 4'hF);
    ex("rst_rdy", S_RDY, 0); ex("rst_mm", S_MM, 0); ex("rst_tc", S_TC, 0);
    tick();
    reset = 1'b1;
    ex("clr_j", S_J, 0); ex("clr_k", S_K, 4'hF); ex("clr_rdy", S_RDY, 0); ex("clr_tc", S_TC, 0);
    tick();
    ld_valid = 1'b0; en = 1'b1; up_dn = 1'b1;
    ex("run_q_noload", S_Q, 0); ex("run_rdy", S_RDY, 1);

    // Count up 12 steps with wrap at 9
    e = 4'd0;
    for (int i = 0; i < 12; i++) begin
      ex("up_q", S_Q, e);
      ex("up_tc", S_TC, (e == 4'd9) ? 4'd1 : 4'd0);
      if (e == 4'd9) begin
        ex("wrap_j", S_J, 4'b0000); ex("wrap_k", S_K, 4'b1001);
      end
      tick();
      e = (e == 4'd9) ? 4'd0 : e + 4'd1;
    end
    ex("up_end_q", S_Q, 4'd2);

    // Load 0 then count down through the wrap
    en = 1'b0; ld_valid = 1'b1; ld_data = 4'd0;
    ex("ld0_j", S_J, 4'b0000); ex("ld0_k", S_K, 4'b0010);
    tick();
    ld_valid = 1'b0; en = 1'b1; up_dn = 1'b0;
    ex("dn0_q", S_Q, 0); ex("dn0_tc", S_TC, 1); ex("dn0_j", S_J, 4'b1001); ex("dn0_k", S_K, 4'b0000);
    tick();
    ex("dn9_q", S_Q, 9); ex("dn9_tc", S_TC, 0);
    tick();
    ex("dn8_q", S_Q, 8);

    // Load wins over count; oversized load saturates
    ld_valid = 1'b1; ld_data = 4'd7;
    ex("ld7_j", S_J, 4'b0111); ex("ld7_k", S_K, 4'b1000); ex("ld7_tc", S_TC, 0);
    tick();
    ex("ld7_q", S_Q, 7);
    ld_data = 4'd12;
    tick();
    ex("ld12_q", S_Q, 9);
    ld_data = 4'd4;
    tick();
    ex("ld4_q", S_Q, 4);

    // Bank divergence: fb=0101 against q=0100
    en = 1'b1; ld_valid = 1'b1; ld_data = 4'd2;
    force_en = 1'b1; force_val = 4'b0101;
    ex("mm_j", S_J, 4'b0000); ex("mm_k", S_K, 4'b0001); ex("mm_rdy", S_RDY, 0); ex("mm_flag0", S_MM, 0);
    tick();
    ex("err_q", S_Q, 4); ex("err_mm", S_MM, 1); ex("err_rdy", S_RDY, 0);
    ex("err_j", S_J, 4'b0000); ex("err_k", S_K, 4'b0001);
    tick();
    ex("err_hold_q", S_Q, 4);
    force_en = 1'b0; ld_valid = 1'b0; en = 1'b0;
    ex("err_sync_rdy", S_RDY, 0); ex("err_sync_k", S_K, 4'b0000);
    tick();
    ex("resync_q", S_Q, 4); ex("resync_rdy", S_RDY, 1); ex("resync_mm", S_MM, 1);

    // Reset while in ERR at q=6
    ld_valid = 1'b1; ld_data = 4'd6;
    tick();
    ld_valid = 1'b0;
    ex("ld6_q", S_Q, 6);
    force_en = 1'b1; force_val = 4'b0000;
    tick();
    ex("err6_q", S_Q, 6); ex("err6_mm", S_MM, 1);
    reset = 1'b0;
    ex("rst_err_j", S_J, 0); ex("rst_err_k", S_K, 4'hF); ex("rst_err_rdy", S_RDY, 0);
    tick();
    ex("rst2_q", S_Q, 0); ex("rst2_mm", S_MM, 0);
    force_en = 1'b0; reset = 1'b1;
    ex("rst2_clr_rdy", S_RDY, 0);
    tick();
    tick();
    ex("rerun_rdy", S_RDY, 1); ex("rerun_q", S_Q, 0); ex("rerun_mm", S_MM, 0);

    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
